single_port_ram_arbiter: RTL
============================

// Module: single_port_ram_arbiter
// PURPOSE
// - Shares one single_port_ram between two requesters (port A, port B) via valid/ready command handshakes.
// - Grants one command at a time: round-robin by default, fixed priority optional.
// - Drives the RAM data/addr/we pins and returns read data with a one-cycle response pulse.
// - Sits between the RAM and its two clients; the RAM itself is instantiated outside this block.
// PARAMETERS
// - ADDR_WIDTH  8   width of request and RAM address buses
// - DATA_WIDTH  8   width of write/read data
// - DEPTH       64  valid RAM words; addresses >= DEPTH are out of range
// PORTS
// - clk           in   1           single clock, rising edge
// - rst_n         in   1           asynchronous reset, active low
// - a_valid/b_valid   in  1        command request from A/B
// - a_we/b_we         in  1        1 = write, 0 = read
// - a_addr/b_addr     in  ADDR_WIDTH   command address
// - a_wdata/b_wdata   in  DATA_WIDTH   write data
// - a_ready/b_ready   out 1        command accepted this cycle
// - a_rsp_valid/b_rsp_valid out 1  one-cycle pulse: read data / write completion
// - a_rsp_err/b_rsp_err     out 1  qualified by rsp_valid: address out of range
// - a_rdata/b_rdata   out DATA_WIDTH   read data, qualified by rsp_valid
// - ram_data      out  DATA_WIDTH  to RAM data
// - ram_addr      out  ADDR_WIDTH  to RAM addr
// - ram_we        out  1           to RAM we
// - ram_q         in   DATA_WIDTH  from RAM q; valid the cycle after ram_addr is sampled
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; all ready/rsp_valid/rsp_err=0, rdata=0, ram_we=0, ram_addr=0,
//   ram_data=0; last_grant=B (so A wins the first tie). Reset mid-operation discards the in-flight command.
// - Handshake: requester holds valid and fields stable until ready; transfer on clk edge with valid&ready.
// - ready is combinational, asserted only in IDLE, for at most one port (the winner).
// - States: IDLE -> ACCESS -> (write) IDLE | (read) RESP -> IDLE.
// - IDLE: if any valid, winner = sole requester, or on tie the port not equal to last_grant;
//   ready(winner)=1; at edge latch addr/wdata/we/owner, update last_grant, go ACCESS.
// - ACCESS (1 cycle): ram_addr/ram_data driven from latch; ram_we=latched we & in-range.
//   Write -> at edge pulse owner rsp_valid next cycle, go IDLE. Read -> go RESP.
// - RESP (1 cycle): ram_we=0, ram_addr held; at edge capture ram_q into owner rdata, pulse rsp_valid.
// - Latency from handshake edge: write rsp_valid 1 cycle later; read rsp_valid 2 cycles later.
//   Throughput: 1 command per 2 cycles (write) / 3 cycles (read); new grant allowed in rsp_valid cycle.
// - rdata holds last value until the next read response for that port.
// - Out of range (addr >= DEPTH): accepted normally, ram_we forced 0, rsp_err=1, read rdata=0.
// - ram_we is high only in ACCESS; never two cycles back-to-back.
// - Tie while a port is already waiting: alternation guarantees each port served within 2 grants.
// CONFIGURATION
// - RAM_ARB_FIXED_PRIO_EN defined: port A always wins ties; last_grant unused; B can starve.
// - Undefined (default): round-robin alternation as above.
// TESTING
// - Reset, A writes 0x01 @0 -> a_ready in cycle 1, ram_we=1 addr=0 next cycle, a_rsp_valid 1 cycle later.
// - A writes 0x01/0x02/0x03 @0/1/2, then reads @0/1/2 -> a_rdata 0x01,0x02,0x03, rsp_err=0.
// - A and B both valid every cycle (A wr @5 0xAA, B wr @6 0xBB) -> grants A,B,A,B...; read back correct.
// - B reads @DEPTH (64) -> b_rsp_err=1, b_rdata=0, ram_we stays 0, RAM contents unchanged.
// - rst_n low during RESP of A read -> ram_we=0, rsp_valid=0 immediately; no pulse after release; state IDLE.
// - With RAM_ARB_FIXED_PRIO_EN, A and B valid continuously -> only A granted while A valid.

Source files
------------

// File: rtl/single_port_ram_arbiter.sv
// Two-port valid/ready arbiter sharing one synchronous single-port RAM.
// RAM_ARB_FIXED_PRIO_EN: port A always wins ties (default: round-robin).
module single_port_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rsp_valid,
    output logic                  a_rsp_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rsp_valid,
    output logic                  b_rsp_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner_b;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_rsp;
    logic [DATA_WIDTH-1:0] w_rsp_data;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_grant_a = a_valid;
`else
    logic r_last_b;
    // On a tie, the port that was not granted last goes first.
    assign w_grant_a = a_valid & (~b_valid | r_last_b);
`endif
    assign w_grant_b = b_valid & ~w_grant_a;
    assign w_accept  = (r_state == S_IDLE) & (a_valid | b_valid);

    assign w_in_range = 32'(r_addr) < 32'(DEPTH);
    assign ram_addr   = r_addr;
    assign ram_data   = r_wdata;

    assign w_rsp = ((r_state == S_ACCESS) & r_we) | (r_state == S_RESP);
    assign w_rsp_data = w_in_range ? ram_q : '0;

    always_comb begin
        w_next  = r_state;
        a_ready = 1'b0;
        b_ready = 1'b0;
        ram_we  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                a_ready = w_grant_a;
                b_ready = w_grant_b;
                if (a_valid | b_valid) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_we = r_we & w_in_range;
                w_next = r_we ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_b   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            a_rsp_valid <= 1'b0;
            a_rsp_err   <= 1'b0;
            a_rdata     <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_err   <= 1'b0;
            b_rdata     <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_last_b    <= 1'b1;
`endif
        end else begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_owner_b <= w_grant_b;
                r_we      <= w_grant_b ? b_we : a_we;
                r_addr    <= w_grant_b ? b_addr : a_addr;
                r_wdata   <= w_grant_b ? b_wdata : a_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
                r_last_b  <= w_grant_b;
`endif
            end
            if (w_rsp) begin
                if (r_owner_b) begin
                    b_rsp_valid <= 1'b1;
                    b_rsp_err   <= ~w_in_range;
                    if (r_state == S_RESP) begin
                        b_rdata <= w_rsp_data;
                    end
                end else begin
                    a_rsp_valid <= 1'b1;
                    a_rsp_err   <= ~w_in_range;
                    if (r_state == S_RESP) begin
                        a_rdata <= w_rsp_data;
                    end
                end
            end
        end
    end

endmodule
